// File: rtl/dcache_req_ctrl.sv
// D-cache request front end: arbitrates LSU/CACOP, runs the ALE check,
// issues to the cache and returns one response. Option: DCACHE_REQ_RR_EN.
module dcache_req_ctrl #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int EXP_WIDTH  = 7
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  lsu_valid,
    output logic                  lsu_ready,
    input  logic [ADDR_WIDTH-1:0] lsu_addr,
    input  logic [3:0]            lsu_type,
    input  logic                  lsu_we,
    input  logic [DATA_WIDTH-1:0] lsu_wdata,
    input  logic                  cacop_valid,
    output logic                  cacop_ready,
    input  logic [ADDR_WIDTH-1:0] cacop_addr,
    input  logic [4:0]            cacop_code,
    output logic                  cache_valid,
    input  logic                  cache_ready,
    output logic [ADDR_WIDTH-1:0] cache_addr,
    output logic [3:0]            cache_type,
    output logic                  cache_we,
    output logic [DATA_WIDTH-1:0] cache_wdata,
    output logic                  cache_cacop_en,
    output logic [4:0]            cache_cacop_code,
    input  logic                  cache_done,
    input  logic [DATA_WIDTH-1:0] cache_rdata,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic                  resp_src,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic [EXP_WIDTH-1:0]  resp_exception,
    output logic [ADDR_WIDTH-1:0] resp_badv
);

    localparam logic [EXP_WIDTH-1:0] EXP_ALE = EXP_WIDTH'(9);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t                state;
    logic                  rb_src;
    logic [ADDR_WIDTH-1:0] rb_addr;
    logic [3:0]            rb_type;
    logic                  rb_we;
    logic [DATA_WIDTH-1:0] rb_wdata;
    logic                  rb_cacop;
    logic [4:0]            rb_code;

    logic                  grant_cacop;
    logic                  idle;
    logic                  rb_ale;
    logic [ADDR_WIDTH-1:0] in_addr;
    logic [3:0]            in_type;

    // Alignment fault: WORD needs addr[1:0]==0, HALF needs addr[0]==0.
    function automatic logic ale_chk(input logic cop, input logic [3:0] t,
                                     input logic [ADDR_WIDTH-1:0] a);
        return !cop && ((t == 4'b1111 && a[1:0] != 2'b00) ||
                        (t == 4'b0011 && a[0]));
    endfunction

`ifdef DCACHE_REQ_RR_EN
    logic last_cacop;

    assign grant_cacop = cacop_valid && (!lsu_valid || !last_cacop);

    // Remember the last winner so the other side goes first on a tie.
    always_ff @(posedge clk) begin
        if (rst)
            last_cacop <= 1'b0;
        else if (lsu_ready || cacop_ready)
            last_cacop <= cacop_ready;
    end
`else
    assign grant_cacop = cacop_valid;
`endif

    assign idle        = (state == IDLE) && !rst;
    assign cacop_ready = idle && grant_cacop;
    assign lsu_ready   = idle && lsu_valid && !grant_cacop;

    assign in_addr = cacop_ready ? cacop_addr : lsu_addr;
    assign in_type = cacop_ready ? 4'b0000 : lsu_type;
    assign rb_ale  = ale_chk(rb_cacop, rb_type, rb_addr);

    assign cache_addr       = rb_addr;
    assign cache_type       = rb_type;
    assign cache_we         = rb_we;
    assign cache_wdata      = rb_wdata;
    assign cache_cacop_en   = rb_cacop;
    assign cache_cacop_code = rb_code;

    // Request FSM: one request in flight, response held until taken.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            rb_src         <= 1'b0;
            rb_addr        <= '0;
            rb_type        <= '0;
            rb_we          <= 1'b0;
            rb_wdata       <= '0;
            rb_cacop       <= 1'b0;
            rb_code        <= '0;
            cache_valid    <= 1'b0;
            resp_valid     <= 1'b0;
            resp_src       <= 1'b0;
            resp_rdata     <= '0;
            resp_exception <= '0;
            resp_badv      <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (lsu_ready || cacop_ready) begin
                        rb_src      <= cacop_ready;
                        rb_addr     <= in_addr;
                        rb_type     <= in_type;
                        rb_we       <= cacop_ready ? 1'b0 : lsu_we;
                        rb_wdata    <= cacop_ready ? '0 : lsu_wdata;
                        rb_cacop    <= cacop_ready;
                        rb_code     <= cacop_ready ? cacop_code : 5'd0;
                        cache_valid <= !ale_chk(cacop_ready, in_type, in_addr);
                        state       <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (rb_ale) begin
                        resp_valid     <= 1'b1;
                        resp_src       <= rb_src;
                        resp_rdata     <= '0;
                        resp_exception <= EXP_ALE;
                        resp_badv      <= rb_addr;
                        state          <= RESP;
                    end else if (cache_ready) begin
                        cache_valid <= 1'b0;
                        if (cache_done) begin
                            resp_valid     <= 1'b1;
                            resp_src       <= rb_src;
                            resp_rdata     <= (rb_we || rb_cacop) ? '0 : cache_rdata;
                            resp_exception <= '0;
                            resp_badv      <= '0;
                            state          <= RESP;
                        end else begin
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (cache_done) begin
                        resp_valid     <= 1'b1;
                        resp_src       <= rb_src;
                        resp_rdata     <= (rb_we || rb_cacop) ? '0 : cache_rdata;
                        resp_exception <= '0;
                        resp_badv      <= '0;
                        state          <= RESP;
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
